// File: rtl/niosii_system_sysid_checker.sv
// rtl/niosii_system_sysid_checker.sv - Boot-time sysid integrity checker
//
// Purpose: reads the ID word (address 0) and the build timestamp word
// (address 1) from the sysid slave through a minimal Avalon-MM read master.
// It compares both words against build-time constants, retries after a
// mismatch, and latches a pass/fail verdict.
//
// Ports:
//   clock, reset      sole rising-edge clock; synchronous active-high reset
//   start             one-cycle request to run a check sequence (IDLE only)
//   avm_address/read  word address and single-cycle read strobe to the slave
//   avm_readdata      slave read data, valid READ_LATENCY cycles after the read
//   busy, done        sequence in progress / one-cycle end-of-sequence pulse
//   pass, id_ok, ts_ok  latched verdict and per-word results of the last attempt
//   id_value, ts_value  last captured words
//   attempts          attempts made in the current or last sequence, saturating
module niosii_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1487650213,
   parameter int          READ_LATENCY       = 0,
   parameter int          MAX_RETRIES        = 3,
   parameter int          RETRY_GAP          = 16,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_ok,
   output logic        ts_ok,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [3:0]  attempts
);

   typedef enum logic [2:0] {
      IDLE, ISSUE_ID, WAIT_ID, ISSUE_TS, WAIT_TS, COMPARE, RETRY_WAIT, DONE
   } state_t;

   // Terminal counts; the latency one is only used when READ_LATENCY > 0.
   localparam logic [2:0] LAT_LAST  = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;
   localparam logic [7:0] GAP_LAST  = 8'(RETRY_GAP - 1);
   localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

   state_t      state_q;
   logic [2:0]  lat_cnt_q;
   logic [7:0]  gap_cnt_q;
   logic        auto_q;      // pending self-start after reset
   logic        avm_address_q;
   logic        avm_read_q;
   logic        busy_q;
   logic        done_q;
   logic        pass_q;
   logic        id_ok_q;
   logic        ts_ok_q;
   logic [31:0] id_value_q;
   logic [31:0] ts_value_q;
   logic [3:0]  attempts_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         lat_cnt_q     <= 3'd0;
         gap_cnt_q     <= 8'd0;
         auto_q        <= AUTO_START;
         avm_address_q <= 1'b0;
         avm_read_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         id_value_q    <= 32'd0;
         ts_value_q    <= 32'd0;
         attempts_q    <= 4'd0;
      end else begin
         // Strobes are asserted only on the transition into an issue/done state.
         avm_read_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start || auto_q) begin
                  auto_q        <= 1'b0;
                  state_q       <= ISSUE_ID;
                  avm_read_q    <= 1'b1;
                  avm_address_q <= 1'b0;
                  busy_q        <= 1'b1;
                  attempts_q    <= 4'd1;   // cleared, then counted for this attempt
                  pass_q        <= 1'b0;
                  id_ok_q       <= 1'b0;
                  ts_ok_q       <= 1'b0;
               end
            end
            ISSUE_ID: begin
               if (READ_LATENCY == 0) begin
                  id_value_q    <= avm_readdata;
                  state_q       <= ISSUE_TS;
                  avm_read_q    <= 1'b1;
                  avm_address_q <= 1'b1;
               end else begin
                  lat_cnt_q <= 3'd0;
                  state_q   <= WAIT_ID;
               end
            end
            WAIT_ID: begin
               if (lat_cnt_q == LAT_LAST) begin
                  id_value_q    <= avm_readdata;
                  lat_cnt_q     <= 3'd0;
                  state_q       <= ISSUE_TS;
                  avm_read_q    <= 1'b1;
                  avm_address_q <= 1'b1;
               end else begin
                  lat_cnt_q <= lat_cnt_q + 3'd1;
               end
            end
            ISSUE_TS: begin
               if (READ_LATENCY == 0) begin
                  ts_value_q <= avm_readdata;
                  state_q    <= COMPARE;
               end else begin
                  lat_cnt_q <= 3'd0;
                  state_q   <= WAIT_TS;
               end
            end
            WAIT_TS: begin
               if (lat_cnt_q == LAT_LAST) begin
                  ts_value_q <= avm_readdata;
                  lat_cnt_q  <= 3'd0;
                  state_q    <= COMPARE;
               end else begin
                  lat_cnt_q <= lat_cnt_q + 3'd1;
               end
            end
            COMPARE: begin
               id_ok_q <= (id_value_q == EXPECTED_ID);
               ts_ok_q <= (ts_value_q == EXPECTED_TIMESTAMP);
               if ((id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TIMESTAMP)) begin
                  pass_q  <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (attempts_q <= RETRY_MAX) begin
                  gap_cnt_q <= 8'd0;
                  state_q   <= RETRY_WAIT;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            RETRY_WAIT: begin
               if (gap_cnt_q == GAP_LAST) begin
                  gap_cnt_q     <= 8'd0;
                  state_q       <= ISSUE_ID;
                  avm_read_q    <= 1'b1;
                  avm_address_q <= 1'b0;
                  if (attempts_q != 4'hF) begin
                     attempts_q <= attempts_q + 4'd1;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + 8'd1;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign avm_address = avm_address_q;
   assign avm_read    = avm_read_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;
   assign attempts    = attempts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// tb/tb_niosii_system_sysid_checker.sv - Self-checking bench for the sysid checker
module tb_niosii_system_sysid_checker;

   localparam logic [31:0] ETS = 32'd1487650213;
   localparam int G  = 16;
   localparam int MR = 3;

   function automatic int lat_of(int k);
      return (k == 1) ? 2 : 0;
   endfunction

   function automatic logic [31:0] eid_of(int k);
      return (k == 0) ? 32'hA5A5_0001 : 32'd0;
   endfunction

   // Slave content: mode 0 matches, mode 1 returns timestamp 0,
   // mode 2 returns a wrong ID on the first attempt of a sequence only.
   function automatic logic [31:0] sval(int md, logic a, int n, logic [31:0] eid);
      if (md == 1) return a ? 32'd0 : eid;
      if (md == 2) return a ? ETS : ((n == 0) ? (eid ^ 32'h1234_5678) : eid);
      return a ? ETS : eid;
   endfunction

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [2:0]  rst, st, rd, ad, busy, done, pass, idok, tsok;
   logic [31:0] rdata [3];
   logic [31:0] idv   [3];
   logic [31:0] tsv   [3];
   logic [3:0]  att   [3];
   int          mode  [3];

   int total = 0;
   int bad   = 0;

   for (genvar g = 0; g < 3; g++) begin : u
      int          attn   = 0;
      int          rd_cyc = -100;
      logic [31:0] rd_val = 32'd0;

      niosii_system_sysid_checker #(
         .EXPECTED_ID        (eid_of(g)),
         .EXPECTED_TIMESTAMP (ETS),
         .READ_LATENCY       (lat_of(g)),
         .MAX_RETRIES        (MR),
         .RETRY_GAP          (G),
         .AUTO_START         (g == 2)
      ) dut (
         .clock        (clock),
         .reset        (rst[g]),
         .start        (st[g]),
         .avm_address  (ad[g]),
         .avm_read     (rd[g]),
         .avm_readdata (rdata[g]),
         .busy         (busy[g]),
         .done         (done[g]),
         .pass         (pass[g]),
         .id_ok        (idok[g]),
         .ts_ok        (tsok[g]),
         .id_value     (idv[g]),
         .ts_value     (tsv[g]),
         .attempts     (att[g])
      );

      // Slave: attn counts completed attempts within the current sequence.
      always @(posedge clock) begin
         if (rst[g] || !busy[g]) attn <= 0;
         else if (rd[g] && ad[g]) attn <= attn + 1;
         if (rd[g]) begin
            rd_cyc <= cyc;
            rd_val <= sval(mode[g], ad[g], attn, eid_of(g));
         end
      end

      assign rdata[g] = (lat_of(g) == 0) ?
                        (rd[g] ? sval(mode[g], ad[g], attn, eid_of(g)) : 32'hDEAD_BEEF) :
                        ((cyc == rd_cyc + lat_of(g)) ? rd_val : 32'hDEAD_BEEF);
   end

   // Behavioural model: one planned sequence per DUT, expressed as its start
   // cycle, attempt count and final values; the timeline follows from arithmetic.
   bit          m_act  [3];
   int          m_from [3];
   int          m_s    [3];
   int          m_n    [3];
   int          m_done [3];
   logic [31:0] m_id   [3];
   logic [31:0] m_ts   [3];
   bit          m_pass [3];
   bit          m_idok [3];
   bit          m_tsok [3];

   int done_seen [3];
   int last_done [3];
   int rd_log    [3][$];

   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic plan(int k, int s);
      int L;
      logic [31:0] iv, tv;
      bit ok;
      L  = lat_of(k);
      ok = 1'b0;
      iv = 32'd0;
      tv = 32'd0;
      m_n[k] = 0;
      for (int i = 0; i <= MR; i++) begin
         iv = sval(mode[k], 1'b0, i, eid_of(k));
         tv = sval(mode[k], 1'b1, i, eid_of(k));
         ok = (iv == eid_of(k)) && (tv == ETS);
         m_n[k] = i + 1;
         if (ok) break;
      end
      m_act[k]  = 1'b1;
      m_from[k] = s;
      m_s[k]    = s;
      m_done[k] = s + 2 * L + 4 + (m_n[k] - 1) * (G + 2 * L + 3);
      m_id[k]   = iv;
      m_ts[k]   = tv;
      m_idok[k] = (iv == eid_of(k));
      m_tsok[k] = (tv == ETS);
      m_pass[k] = ok;
      rd_log[k].delete();
   endtask

   task automatic model_reset(int k, int r);
      m_act[k]  = 1'b0;
      m_from[k] = r + 1;
   endtask

   task automatic check(int k);
      int c, L, P, rel, a, an, e_addr;
      bit e_rd, e_busy, e_done;
      c = cyc; L = lat_of(k); P = G + 2 * L + 3;
      e_rd = 0; e_busy = 0; e_done = 0; e_addr = -1;
      if (m_act[k]) begin
         rel = c - m_s[k];
         if (rel >= 1 && c <= m_done[k]) e_busy = 1;
         if (c == m_done[k]) e_done = 1;
         if (rel >= 1 && c < m_done[k]) begin
            an = (rel - 1) / P;
            a  = (rel - 1) % P;
            if (an < m_n[k]) begin
               if (a == 0 || a == L + 1) e_rd = 1;
               if (a <= L) e_addr = 0;
               else if (a <= 2 * L + 1) e_addr = 1;
            end
         end
      end
      cmp($sformatf("d%0d_read@%0d", k, c), 32'(rd[k]), 32'(e_rd));
      cmp($sformatf("d%0d_busy@%0d", k, c), 32'(busy[k]), 32'(e_busy));
      cmp($sformatf("d%0d_done@%0d", k, c), 32'(done[k]), 32'(e_done));
      if (e_addr >= 0) cmp($sformatf("d%0d_addr@%0d", k, c), 32'(ad[k]), 32'(e_addr));
      if (!m_act[k] || c >= m_done[k]) begin
         cmp($sformatf("d%0d_pass@%0d", k, c), 32'(pass[k]), m_act[k] ? 32'(m_pass[k]) : 32'd0);
         cmp($sformatf("d%0d_idok@%0d", k, c), 32'(idok[k]), m_act[k] ? 32'(m_idok[k]) : 32'd0);
         cmp($sformatf("d%0d_tsok@%0d", k, c), 32'(tsok[k]), m_act[k] ? 32'(m_tsok[k]) : 32'd0);
         cmp($sformatf("d%0d_att@%0d", k, c), 32'(att[k]), m_act[k] ? 32'(m_n[k]) : 32'd0);
         cmp($sformatf("d%0d_idv@%0d", k, c), idv[k], m_act[k] ? m_id[k] : 32'd0);
         cmp($sformatf("d%0d_tsv@%0d", k, c), tsv[k], m_act[k] ? m_ts[k] : 32'd0);
      end
   endtask

   always @(negedge clock) begin
      for (int k = 0; k < 3; k++) begin
         if (done[k] === 1'b1) begin
            done_seen[k] = done_seen[k] + 1;
            last_done[k] = cyc;
         end
         if (rd[k] === 1'b1) rd_log[k].push_back(cyc);
         if (cyc >= m_from[k]) check(k);
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic run_until_done(int k, int prev);
      int t;
      t = 0;
      while (done_seen[k] == prev && t < 400) begin
         step();
         t++;
      end
      cmp($sformatf("d%0d_done_timeout", k), 32'(t < 400), 32'd1);
      step();
      step();
   endtask

   task automatic do_start(int k, output int s, output int prev);
      s    = cyc;
      prev = done_seen[k];
      st[k] = 1'b1;
      plan(k, s);
      step();
      st[k] = 1'b0;
   endtask

   initial begin
      int s, p;
      rst = 3'b111;
      st  = 3'b000;
      for (int k = 0; k < 3; k++) begin
         mode[k] = 0; m_act[k] = 0; m_from[k] = 1; m_s[k] = 0; m_n[k] = 0; m_done[k] = 0;
         done_seen[k] = 0; last_done[k] = 0;
      end
      repeat (3) step();

      // Release reset: dut2 self-starts, dut0/dut1 stay idle.
      s = cyc;
      p = done_seen[2];
      rst = 3'b000;
      plan(2, s);
      run_until_done(2, p);
      cmp("auto_done_cycle", 32'(last_done[2] - s), 32'd4);
      cmp("auto_pass", 32'(pass[2]), 32'd1);

      // Matching slave, latency 0.
      mode[0] = 0;
      do_start(0, s, p);
      run_until_done(0, p);
      cmp("l0_done_cycle", 32'(last_done[0] - s), 32'd4);
      cmp("l0_read_count", 32'(rd_log[0].size()), 32'd2);
      if (rd_log[0].size() == 2) begin
         cmp("l0_read0_cycle", 32'(rd_log[0][0] - s), 32'd1);
         cmp("l0_read1_cycle", 32'(rd_log[0][1] - s), 32'd2);
      end
      cmp("l0_pass", 32'(pass[0]), 32'd1);
      cmp("l0_attempts", 32'(att[0]), 32'd1);
      cmp("l0_ts_value", tsv[0], 32'd1487650213);
      cmp("l0_id_value", idv[0], 32'hA5A5_0001);

      // Matching slave, latency 2.
      do_start(1, s, p);
      run_until_done(1, p);
      cmp("l2_done_cycle", 32'(last_done[1] - s), 32'd8);
      cmp("l2_read_count", 32'(rd_log[1].size()), 32'd2);
      if (rd_log[1].size() == 2) begin
         cmp("l2_read0_cycle", 32'(rd_log[1][0] - s), 32'd1);
         cmp("l2_read1_cycle", 32'(rd_log[1][1] - s), 32'd4);
      end
      cmp("l2_pass", 32'(pass[1]), 32'd1);

      // Timestamp always wrong: all retries used.
      mode[0] = 1;
      do_start(0, s, p);
      run_until_done(0, p);
      cmp("ts_bad_done_cycle", 32'(last_done[0] - s), 32'd61);
      cmp("ts_bad_attempts", 32'(att[0]), 32'd4);
      cmp("ts_bad_pass", 32'(pass[0]), 32'd0);
      cmp("ts_bad_idok", 32'(idok[0]), 32'd1);
      cmp("ts_bad_tsok", 32'(tsok[0]), 32'd0);
      cmp("ts_bad_read_count", 32'(rd_log[0].size()), 32'd8);
      if (rd_log[0].size() >= 3) cmp("ts_bad_retry_read", 32'(rd_log[0][2] - s), 32'd20);

      // Wrong ID on the first attempt only.
      mode[0] = 2;
      do_start(0, s, p);
      run_until_done(0, p);
      repeat (5) step();
      cmp("id_retry_done_cycle", 32'(last_done[0] - s), 32'd23);
      cmp("id_retry_attempts", 32'(att[0]), 32'd2);
      cmp("id_retry_pass", 32'(pass[0]), 32'd1);
      cmp("id_retry_done_pulses", 32'(done_seen[0] - p), 32'd1);

      // start held high from ISSUE_TS through DONE is ignored.
      mode[0] = 0;
      do_start(0, s, p);
      step();
      st[0] = 1'b1;
      repeat (3) step();
      st[0] = 1'b0;
      repeat (10) step();
      cmp("busy_start_done_pulses", 32'(done_seen[0] - p), 32'd1);
      cmp("busy_start_done_cycle", 32'(last_done[0] - s), 32'd4);

      // Reset asserted in the first WAIT_TS cycle of a latency-2 sequence.
      do_start(1, s, p);
      repeat (4) step();
      rst[1] = 1'b1;
      model_reset(1, cyc);
      step();
      cmp("rst_busy", 32'(busy[1]), 32'd0);
      cmp("rst_attempts", 32'(att[1]), 32'd0);
      cmp("rst_id_value", idv[1], 32'd0);
      repeat (3) step();
      rst[1] = 1'b0;
      repeat (3) step();
      cmp("rst_no_done", 32'(done_seen[1] - p), 32'd0);

      // Recovery after reset.
      do_start(1, s, p);
      run_until_done(1, p);
      cmp("rst_recover_done_cycle", 32'(last_done[1] - s), 32'd8);
      cmp("rst_recover_pass", 32'(pass[1]), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
